// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate defaults, bit-timing derivations and receiver states.
// The transmitter uses the same helpers so both sides agree on BIT_TIME.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ  = 125_000_000;
    localparam int unsigned DEF_BAUD_RATE = 115_200;

    function automatic int unsigned bit_time(int unsigned clk_freq, int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned half_bit(int unsigned clk_freq, int unsigned baud_rate);
        return bit_time(clk_freq, baud_rate) / 2;
    endfunction

    localparam int unsigned DEF_BIT_TIME = bit_time(DEF_CLK_FREQ, DEF_BAUD_RATE);
    localparam int unsigned DEF_HALF_BIT = half_bit(DEF_CLK_FREQ, DEF_BAUD_RATE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART signal bundle: serial line in, received byte and status strobes out.
interface uart_rx_if;

    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 so an idle-high line
// does not look like an edge when reset releases.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, byte strobe and framing-error strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
    input logic       clk,
    input logic       rst,
    uart_rx_if.slave  bus
);

    localparam logic [15:0] BitLast  = 16'(bit_time(CLK_FREQ, BAUD_RATE) - 1);
    localparam logic [15:0] HalfLast = 16'(half_bit(CLK_FREQ, BAUD_RATE) - 1);

    logic           rx_s;
    uart_rx_state_e state_q, state_d;
    logic [15:0]    clk_count_q, clk_count_d;
    logic [2:0]     bit_index_q, bit_index_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           frame_err_q, frame_err_d;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q + 16'd1;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_count_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (clk_count_q == HalfLast) begin
                    clk_count_d = '0;
                    bit_index_d = '0;
                    // A line that is high again at mid-start-bit was only a glitch.
                    state_d     = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_count_q == BitLast) begin
                    clk_count_d          = '0;
                    shift_d[bit_index_q] = rx_s;
                    if (bit_index_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (clk_count_q == BitLast) begin
                    clk_count_d = '0;
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                clk_count_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                clk_count_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
